// File: rtl/regs_mp.sv
// regs_mp: parametrised integer register file with NRD synchronous read
// ports, one write port, optional write-to-read bypass, optional hard-wired
// zero register and a sequential clear engine.
//
// Ports:
//   i_clk      clock, all state changes on the rising edge
//   i_rst      synchronous active-high reset; restarts the clear engine
//   i_clr      one-cycle clear request, ignored while o_busy=1
//   i_hold     1 = read-data registers keep their value (writes still commit)
//   i_we       write enable
//   i_addr_wr  write address
//   i_dat_wr   write data
//   i_addr_rd  packed read addresses, port k at [k*AREG +: AREG]
//   o_dat_rd   packed read data, port k at [k*XLEN +: XLEN], 1-cycle latency
//   o_busy     clear engine active; the pipeline must stall
module regs_mp #(
  parameter int XLEN     = 32,
  parameter int AREG     = 5,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_hold,
  input  logic                 i_we,
  input  logic [AREG-1:0]      i_addr_wr,
  input  logic [XLEN-1:0]      i_dat_wr,
  input  logic [NRD*AREG-1:0]  i_addr_rd,
  output logic [NRD*XLEN-1:0]  o_dat_rd,
  output logic                 o_busy
);

  // Array index width; never wider than AREG because NREGS <= 2**AREG.
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [AREG-1:0] LAST_PTR = AREG'(NREGS - 1);

  logic [0:0]          r_state;
  logic [AREG-1:0]     r_ptr;
  logic [XLEN-1:0]     r_mem [NREGS];
  logic [NRD*XLEN-1:0] r_rd_p1;
  logic [NRD*XLEN-1:0] w_rd_next;
  logic                w_wr_ok;

  // Addresses that always read as zero and never accept a write:
  // beyond the implemented range, or the hard-wired x0.
  function automatic logic is_zero_slot(input logic [AREG-1:0] a);
    return (32'(a) >= NREGS) || ((ZERO_REG != 0) && (a == '0));
  endfunction

  // A write commits only in RUN and only to a real, writable entry.
  assign w_wr_ok = i_we && (r_state == S_RUN) && !is_zero_slot(i_addr_wr);

  // Clear engine: one entry per cycle, busy until the last entry is zeroed.
  // Reaching LAST_PTR may wrap r_ptr when NREGS == 2**AREG; harmless since
  // the state leaves CLEAR on that same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else if (r_state == S_CLEAR) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == LAST_PTR) r_state <= S_RUN;
    end else if (i_clr) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end
  end

  // Array contents are left untouched while reset is asserted; the clear
  // engine zeroes them once reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_ptr[IW-1:0]] <= '0;
      end else if (w_wr_ok) begin
        r_mem[i_addr_wr[IW-1:0]] <= i_dat_wr;
      end
    end
  end

  always_comb begin
    w_rd_next = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AREG-1:0] ra;
      ra = i_addr_rd[k*AREG +: AREG];
      if ((r_state == S_CLEAR) || is_zero_slot(ra)) begin
        w_rd_next[k*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && w_wr_ok && (ra == i_addr_wr)) begin
        w_rd_next[k*XLEN +: XLEN] = i_dat_wr;
      end else begin
        w_rd_next[k*XLEN +: XLEN] = r_mem[ra[IW-1:0]];
      end
    end
  end

  // ---- stage p1: registered read data ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_p1 <= '0;
    end else if (!i_hold) begin
      r_rd_p1 <= w_rd_next;
    end
  end

  assign o_dat_rd = r_rd_p1;
  assign o_busy   = (r_state == S_CLEAR);

endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp: directed bench for regs_mp. Three instances share the clock
// and reset: dut_a (defaults, BYPASS=1), dut_b (BYPASS=0, same stimulus as
// dut_a) and dut_c (NRD=4, NREGS=16, ZERO_REG=0, own stimulus).
module tb_regs_mp;

  logic clk;
  logic rst, clr, hold, we;
  logic [4:0]  awr;
  logic [31:0] dwr;
  logic [9:0]  ard;
  logic [63:0] dat_a, dat_b;
  logic        busy_a, busy_b;

  logic        c_clr, c_hold, c_we;
  logic [4:0]  c_awr;
  logic [31:0] c_dwr;
  logic [19:0] c_ard;
  logic [127:0] c_dat;
  logic        c_busy;

  int n_chk, n_err;
  int cnt, cnt_c;

  regs_mp #(.XLEN(32), .AREG(5), .NREGS(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_hold(hold), .i_we(we),
    .i_addr_wr(awr), .i_dat_wr(dwr), .i_addr_rd(ard),
    .o_dat_rd(dat_a), .o_busy(busy_a));

  regs_mp #(.XLEN(32), .AREG(5), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_hold(hold), .i_we(we),
    .i_addr_wr(awr), .i_dat_wr(dwr), .i_addr_rd(ard),
    .o_dat_rd(dat_b), .o_busy(busy_b));

  regs_mp #(.XLEN(32), .AREG(5), .NREGS(16), .NRD(4), .BYPASS(1), .ZERO_REG(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_clr(c_clr), .i_hold(c_hold), .i_we(c_we),
    .i_addr_wr(c_awr), .i_dat_wr(c_dwr), .i_addr_rd(c_ard),
    .o_dat_rd(c_dat), .o_busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; clr = 1'b0; hold = 1'b0; we = 1'b0;
    awr = '0; dwr = '0; ard = '0;
    c_clr = 1'b0; c_hold = 1'b0; c_we = 1'b0;
    c_awr = '0; c_dwr = '0; c_ard = '0;

    // Reset for two cycles
    tick(); tick();
    chk("rst_busy_a", 128'(busy_a), 128'd1);
    chk("rst_dat_a", 128'(dat_a), 128'd0);
    chk("rst_busy_c", 128'(c_busy), 128'd1);

    // Clear after reset: busy for exactly NREGS cycles
    rst = 1'b0;
    cnt = 0; cnt_c = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      if (c_busy) cnt_c++;
      tick();
    end
    chk("clr_len_a", 128'(cnt), 128'd32);
    chk("clr_len_c", 128'(cnt_c), 128'd16);
    chk("clr_busy_b", 128'(busy_b), 128'd0);

    for (int r = 1; r < 32; r++) begin
      ard = {5'(32 - r), 5'(r)};
      tick();
      chk($sformatf("clr_x%0d", r), 128'(dat_a), 128'd0);
    end

    // Write/read and x0
    we = 1'b1; awr = 5'd5; dwr = 32'hDEADBEEF; tick();
    awr = 5'd0; dwr = 32'h12345678; tick();
    we = 1'b0; ard = {5'd0, 5'd5}; tick();
    chk("wr_x5_a", 128'(dat_a[31:0]), 128'hDEADBEEF);
    chk("wr_x0_a", 128'(dat_a[63:32]), 128'h0);
    chk("wr_x5_b", 128'(dat_b[31:0]), 128'hDEADBEEF);
    chk("wr_x0_b", 128'(dat_b[63:32]), 128'h0);

    // Bypass
    we = 1'b1; awr = 5'd7; dwr = 32'hCAFE0001; ard = {5'd7, 5'd7}; tick();
    chk("byp_a", 128'(dat_a), 128'hCAFE0001_CAFE0001);
    chk("byp_b_old", 128'(dat_b), 128'h0);
    we = 1'b0; tick();
    chk("byp_b_new", 128'(dat_b), 128'hCAFE0001_CAFE0001);

    // Hold
    ard = {5'd5, 5'd5}; tick();
    chk("hold_pre", 128'(dat_a), 128'hDEADBEEF_DEADBEEF);
    hold = 1'b1; we = 1'b1; awr = 5'd5; dwr = 32'h1; ard = {5'd7, 5'd3};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_%0d", i), 128'(dat_a), 128'hDEADBEEF_DEADBEEF);
    end
    hold = 1'b0; we = 1'b0; ard = {5'd5, 5'd5}; tick();
    chk("hold_post", 128'(dat_a), 128'h1_00000001);

    // Runtime clear, writes during busy dropped, reset mid-clear
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("rclr_busy", 128'(busy_a), 128'd1);
    we = 1'b1; awr = 5'd5; dwr = 32'h77;
    for (int i = 0; i < 9; i++) tick();
    chk("rclr_busy10", 128'(busy_a), 128'd1);
    chk("rclr_dat0", 128'(dat_a), 128'h0);
    rst = 1'b1; tick();
    rst = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      tick();
    end
    we = 1'b0;
    chk("rclr_len", 128'(cnt), 128'd32);
    ard = {5'd5, 5'd5}; tick();
    chk("rclr_x5_a", 128'(dat_a), 128'h0);
    chk("rclr_x5_b", 128'(dat_b), 128'h0);

    // Parameter sweep instance: x0 writable, out-of-range address ignored
    c_we = 1'b1;
    c_awr = 5'd0;  c_dwr = 32'hA5;   tick();
    c_awr = 5'd20; c_dwr = 32'hFF;   tick();
    c_awr = 5'd3;  c_dwr = 32'h33;   tick();
    c_awr = 5'd15; c_dwr = 32'h0F0F; tick();
    c_we = 1'b0;
    c_ard = {5'd4, 5'd3, 5'd20, 5'd0}; tick();
    chk("c_p0_x0", 128'(c_dat[31:0]), 128'hA5);
    chk("c_p1_a20", 128'(c_dat[63:32]), 128'h0);
    chk("c_p2_x3", 128'(c_dat[95:64]), 128'h33);
    chk("c_p3_x4", 128'(c_dat[127:96]), 128'h0);
    c_ard = {5'd0, 5'd3, 5'd15, 5'd0}; tick();
    chk("c_mix", c_dat, {32'hA5, 32'h33, 32'h0F0F, 32'hA5});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised successor to the CPU integer register file.
- Configurable data width, depth and number of synchronous read ports; one write port.
- Optional write-to-read bypass and optional hard-wired zero register.
- Adds a sequential clear engine, run after reset or on request, with a busy flag and a read-hold (stall) input so the pipeline can freeze operand outputs.

Parameters:
- XLEN, 32, data width in bits.
- AREG, 5, address width in bits.
- NREGS, 32, number of implemented registers; must satisfy 2 <= NREGS <= 2**AREG.
- NRD, 2, number of read ports; legal range 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns the old value.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_clr  in  1  one-cycle pulse requesting a full clear; ignored while o_busy=1.
- i_hold  in  1  1 = all read-data registers keep their value; writes still occur.
- i_we  in  1  write enable.
- i_addr_wr  in  AREG  write address.
- i_dat_wr  in  XLEN  write data.
- i_addr_rd  in  NRD*AREG  read addresses; port k uses bits [k*AREG +: AREG].
- o_dat_rd  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- o_busy  out  1  clear engine active; the pipeline must stall.

Behaviour:
- Reset (i_rst=1, synchronous): FSM goes to CLEAR, clear pointer = 0, o_dat_rd = 0, o_busy = 1. Array contents are not touched during reset cycles.
- FSM has two states, CLEAR and RUN.
- CLEAR, each cycle with i_rst=0:
  - Write 0 to entry[ptr], then ptr++.
  - On the cycle that writes NREGS-1, go to RUN; o_busy reads 0 from the next cycle.
  - o_busy is therefore high for exactly NREGS cycles after reset release.
  - i_we and i_clr are ignored; the next o_dat_rd values are forced to 0 unless i_hold=1.
- RUN:
  - i_clr=1 moves to CLEAR with ptr=0. o_busy is 1 from the next cycle.
  - If i_we=1 in the same cycle as i_clr, the write is still performed.
- Reset mid-clear: ptr restarts at 0 and the full NREGS-cycle clear repeats.
- Write (RUN only): at the clock edge, entry[i_addr_wr] <= i_dat_wr if i_we=1 and none of these hold:
  - ZERO_REG=1 and address = 0;
  - address >= NREGS.
- Read latency is 1 cycle. Each port k registers its data when i_hold=0, selected in this priority:
  1. CLEAR state: 0.
  2. addr >= NREGS, or ZERO_REG=1 and addr=0: 0.
  3. BYPASS=1 and i_we=1 and addr = i_addr_wr, with the write valid per the rules above: i_dat_wr.
  4. Otherwise: entry[addr], the pre-edge value.
- Hold: with i_hold=1, o_dat_rd is unchanged and a simultaneous write still commits. After release, the next registered read reflects the updated array.
- Multiple ports reading the same address return identical data, with the bypass applied to every matching port.
- No write-write conflicts exist (single write port).

Test Plan:
- Clear after reset: i_rst high 2 cycles, then low. o_busy=1 for exactly 32 cycles, then 0. Reading x1..x31 afterwards returns 0x00000000.
- Write/read and x0: write x5=0xDEADBEEF and x0=0x12345678. Read port0=x5, port1=x0 next cycle. Data is 0xDEADBEEF and 0x0 one cycle after the reads.
- Bypass: in the same cycle write x7=0xCAFE0001 while both ports read x7. With BYPASS=1 both ports give 0xCAFE0001; with BYPASS=0 both give the old value 0x0.
- Hold: outputs show x5=0xDEADBEEF; assert i_hold 3 cycles while writing x5=0x1 and changing the read address. Outputs stay 0xDEADBEEF. After release, a read of x5 returns 0x1.
- Runtime clear plus reset mid-clear:
  - Pulse i_clr with x5 nonzero; writes during busy are dropped. Assert i_rst after 10 busy cycles.
  - o_busy then lasts 32 further cycles; x5 reads 0 afterwards.
- Parameter sweep: NRD=4, NREGS=16, AREG=5, ZERO_REG=0.
  - x0 is writable: 0xA5 reads back.
  - Address 20 reads 0 and a write to it is ignored.
  - All 4 ports return correct independent data.
